// File: rtl/mem_arbiter_2to1.sv
// Two-requester round-robin arbiter in front of a single ext_mem port.
// One transaction in flight at a time: IDLE (arbitrate) -> ISSUE (req pulse) -> WAIT (response/timeout).
module mem_arbiter_2to1 #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit RESET_PRIO     = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,
  output logic        m1_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);
  localparam int CW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        r_state, w_next;
  logic          r_gnt, r_last, r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_addr, r_wdata;
  logic [CW-1:0] r_cnt;

  logic        w_any, w_pick, w_done, w_tout, w_cpl;
  logic [31:0] w_rd;

  assign w_any  = m0_req_i | m1_req_i;
  // On a tie the requester that did not win last time goes first.
  assign w_pick = (m0_req_i & m1_req_i) ? ~r_last : m1_req_i;
  assign w_done = (r_state == S_WAIT) & mem_ready_i;
  assign w_tout = (TIMEOUT_CYCLES != 0) & (r_state == S_WAIT) & ~mem_ready_i & (r_cnt == LAST);
  assign w_cpl  = w_done | w_tout;
  assign w_rd   = (w_done & ~r_we) ? mem_rdata_i : 32'h0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_cpl) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= ~RESET_PRIO;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) begin
        r_gnt   <= w_pick;
        r_last  <= w_pick;
        r_we    <= w_pick ? m1_we_i    : m0_we_i;
        r_be    <= w_pick ? m1_be_i    : m0_be_i;
        r_addr  <= w_pick ? m1_addr_i  : m0_addr_i;
        r_wdata <= w_pick ? m1_wdata_i : m0_wdata_i;
      end
      if (r_state == S_ISSUE) r_cnt <= '0;
      else if (r_state == S_WAIT && !mem_ready_i) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign mem_req_o   = (r_state == S_ISSUE);
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

  assign m0_ready_o = w_cpl  & ~r_gnt;
  assign m0_err_o   = w_tout & ~r_gnt;
  assign m0_rdata_o = r_gnt ? 32'h0 : w_rd;
  assign m1_ready_o = w_cpl  & r_gnt;
  assign m1_err_o   = w_tout & r_gnt;
  assign m1_rdata_o = r_gnt ? w_rd : 32'h0;
endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Scoreboard bench for mem_arbiter_2to1 with a one-cycle-latency ext_mem stand-in.
module tb_mem_arbiter_2to1;
  logic        clk = 1'b0, rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic        m0_ready, m0_err, m1_ready, m1_err, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall = 0;

  mem_arbiter_2to1 #(.TIMEOUT_CYCLES(16), .RESET_PRIO(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_rdata_o(m0_rdata), .m0_ready_o(m0_ready), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_rdata_o(m1_rdata), .m1_ready_o(m1_ready), .m1_err_o(m1_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
  typedef struct { logic port; logic [31:0] rdata; logic err; } exp_t;
  cmd_t q0[$], q1[$];
  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0, ld0 = 0, ld1 = 0;

  // ext_mem stand-in: answers one cycle after the request pulse unless stalled.
  logic [31:0] ram [0:255];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      mem_ready <= mem_req && !stall;
      if (mem_req) begin
        if (mem_we) begin
          for (int k = 0; k < 4; k++)
            if (mem_be[k]) ram[mem_addr[9:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
        end else mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Requester models: hold a command until its ready pulse, then take the next one.
  initial begin
    logic s0, s1;
    cmd_t c;
    forever begin
      @(negedge clk);
      s0 = m0_ready; s1 = m1_ready;
      @(posedge clk); #1;
      if (rst) begin
        m0_req = 0; m1_req = 0;
      end else begin
        if (m0_req && s0) m0_req = 0;
        if (!m0_req && q0.size() > 0) begin
          c = q0.pop_front();
          m0_we = c.we; m0_be = c.be; m0_addr = c.addr; m0_wdata = c.wdata; m0_req = 1; ld0 = cyc;
        end
        if (m1_req && s1) m1_req = 0;
        if (!m1_req && q1.size() > 0) begin
          c = q1.pop_front();
          m1_we = c.we; m1_be = c.be; m1_addr = c.addr; m1_wdata = c.wdata; m1_req = 1; ld1 = cyc;
        end
      end
    end
  end

  // Scoreboard: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    logic p;
    if (m0_ready || m1_ready) begin
      n_cmp++;
      if (m0_ready && m1_ready) begin
        n_bad++; $display("FAIL both_ready: m0_ready=1 m1_ready=1, required one at a time");
      end else if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL unexpected_cpl: m0_ready=%0b m1_ready=%0b at cyc %0d, none expected", m0_ready, m1_ready, cyc);
      end else begin
        e = exp_q.pop_front();
        p = m1_ready;
        if (p !== e.port || (p ? m1_rdata : m0_rdata) !== e.rdata || (p ? m1_err : m0_err) !== e.err) begin
          n_bad++;
          $display("FAIL cpl: got port=%0d rdata=%h err=%0b, required port=%0d rdata=%h err=%0b",
                   p, p ? m1_rdata : m0_rdata, p ? m1_err : m0_err, e.port, e.rdata, e.err);
        end
        n_cmp++;
        if ((p ? m0_rdata : m1_rdata) !== 32'h0 || (p ? m0_err : m1_err) !== 1'b0) begin
          n_bad++; $display("FAIL idle_port: non-granted rdata=%h err=%0b, required 0/0",
                            p ? m0_rdata : m1_rdata, p ? m0_err : m1_err);
        end
      end
    end
  end

  task automatic push(input bit port, input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    cmd_t c;
    exp_t e;
    c.we = we; c.be = be; c.addr = addr; c.wdata = wdata;
    e.port = port; e.rdata = rdata; e.err = err;
    if (port) q1.push_back(c); else q0.push_back(c);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !m0_req && !m1_req) begin
        ok = 1; break;
      end
    end
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'h0) begin
      n_bad++; $display("FAIL reset_mem: mem outputs=%h, required 0", {mem_req, mem_we, mem_be, mem_addr, mem_wdata});
    end
    n_cmp++;
    if ({m0_ready, m0_err, m0_rdata, m1_ready, m1_err, m1_rdata} !== 68'h0) begin
      n_bad++; $display("FAIL reset_req: requester outputs nonzero, required 0");
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req: mem_req=%0b, required 0", mem_req); end
    end
  endtask

  // First tie after reset goes to m0; m0 re-requesting at once then loses the next tie to m1.
  task automatic test_tie;
    bit ok;
    int d0 = -1, d1 = -1, t;
    push(0, 1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    push(1, 0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    push(0, 0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    @(posedge clk); #2;
    t = ld0;
    for (int i = 0; i < 8 && d1 < 0; i++) begin
      @(negedge clk);
      if (m0_ready && d0 < 0) d0 = cyc;
      if (m1_ready) d1 = cyc;
    end
    n_cmp++;
    if (d0 !== t + 2) begin n_bad++; $display("FAIL tie_m0: done cyc=%0d, required %0d", d0, t + 2); end
    n_cmp++;
    if (d1 !== t + 5) begin n_bad++; $display("FAIL tie_m1: done cyc=%0d, required %0d", d1, t + 5); end
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tie_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_byte_en;
    bit ok;
    push(1, 1, 4'b1111, 32'h20, 32'hFFFFFFFF, 32'h0, 0);
    push(1, 1, 4'b0011, 32'h20, 32'h1234ABCD, 32'h0, 0);
    push(1, 1, 4'b0000, 32'h20, 32'h55555555, 32'h0, 0);
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL be_drain1: pending=%0d, required 0", exp_q.size()); end
    push(0, 0, 4'hF, 32'h20, 32'h0, 32'hFFFFABCD, 0);
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL be_drain2: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_latency;
    int rq = -1, dn = -1, nrq = 0;
    bit m1s = 0;
    push(0, 0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_req) begin nrq++; rq = cyc; end
      if (m0_ready) dn = cyc;
      if (m1_ready) m1s = 1;
    end
    n_cmp++;
    if (rq !== ld0 + 1 || nrq !== 1) begin
      n_bad++; $display("FAIL lat_req: req cyc=%0d count=%0d, required cyc %0d count 1", rq, nrq, ld0 + 1);
    end
    n_cmp++;
    if (dn !== ld0 + 2) begin n_bad++; $display("FAIL lat_ready: cyc=%0d, required %0d", dn, ld0 + 2); end
    n_cmp++;
    if (m1s !== 1'b0) begin n_bad++; $display("FAIL lat_m1: m1_ready seen=%0b, required 0", m1s); end
  endtask

  task automatic test_timeout;
    bit ok;
    int dn = -1, nrq = 0;
    stall = 1;
    push(0, 0, 4'hF, 32'h10, 32'h0, 32'h0, 1);
    for (int i = 0; i < 25 && dn < 0; i++) begin
      @(negedge clk);
      if (mem_req) nrq++;
      if (m0_ready) dn = cyc;
    end
    stall = 0;
    n_cmp++;
    if (dn !== ld0 + 17 || nrq !== 1) begin
      n_bad++; $display("FAIL timeout: err cyc=%0d reqs=%0d, required cyc %0d reqs 1", dn, nrq, ld0 + 17);
    end
    push(0, 0, 4'hF, 32'h20, 32'h0, 32'hFFFFABCD, 0);
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL timeout_recover: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset;
    bit ok, seen = 0;
    cmd_t c;
    c.we = 1; c.be = 4'hF; c.addr = 32'h30; c.wdata = 32'hA5A5A5A5;
    stall = 1;
    q0.push_back(c);
    for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = mem_req; end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mem_addr !== 32'h30 || mem_we !== 1'b1) begin
      n_bad++; $display("FAIL wait_hold: addr=%h we=%0b, required 30/1", mem_addr, mem_we);
    end
    rst = 1; #1;
    n_cmp++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, m0_ready, m0_err, m1_ready, m1_err} !== 74'h0) begin
      n_bad++; $display("FAIL async_rst: outputs not cleared, addr=%h we=%0b", mem_addr, mem_we);
    end
    @(posedge clk); @(negedge clk);
    rst = 0; stall = 0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0 || m0_req !== 1'b0) begin
      n_bad++; $display("FAIL post_rst: mem_req=%0b m0_req=%0b, required 0/0", mem_req, m0_req);
    end
    push(0, 0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rst_reissue: pending=%0d, required 0", exp_q.size()); end
  endtask

  // Last grant before this test is m0, so the stream must open with m1 and alternate.
  task automatic test_back_to_back;
    bit ok;
    int n0 = 0, n1 = 0, alt = 0, first = -1, last = -1;
    logic prev = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(1, 0, 4'hF, 32'h20, 32'h0, 32'hFFFFABCD, 0);
      push(0, 0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    end
    for (int i = 0; i < 60 && (n0 + n1) < 10; i++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        if (first < 0) first = cyc;
        else if (m1_ready === prev) alt++;
        prev = m1_ready; last = cyc;
        if (m1_ready) n1++; else n0++;
      end
    end
    n_cmp++;
    if (n0 !== 5 || n1 !== 5) begin n_bad++; $display("FAIL b2b_count: m0=%0d m1=%0d, required 5/5", n0, n1); end
    n_cmp++;
    if (alt !== 0) begin n_bad++; $display("FAIL b2b_alt: repeats=%0d, required 0", alt); end
    n_cmp++;
    if (last - first !== 27) begin n_bad++; $display("FAIL b2b_rate: span=%0d, required 27", last - first); end
    wait_drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_tie;
    test_byte_en;
    test_latency;
    test_timeout;
    test_mid_reset;
    test_back_to_back;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "bench timeout");
  end
endmodule
